// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared constants and FSM state type for the restoring divider
//
// Purpose : operand width, iteration count, step counter width and the
//           control state encoding used by divider_control and
//           restoring_divider.
// Ports   : none (package).
package divider_pkg;

  localparam int WIDTH = 8;
  localparam int ITER  = 8;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/HexDriver.sv
// rtl/HexDriver.sv - nibble to active-low seven-segment decoder
//
// Purpose : combinational decode of a 4-bit value to segments {g,f,e,d,c,b,a},
//           active low (0 lights a segment).
// Ports   : i_hex [3:0] nibble in
//           o_seg [6:0] segment image out
module HexDriver (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_hex)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/divider_control.sv
// rtl/divider_control.sv - sequencing FSM for the restoring divider
//
// Purpose : IDLE/LOAD/STEP/DONE controller with the 8-iteration step counter.
//           Optional macro DIVIDER_DBZ_TRAP_EN: LOAD with a zero divisor
//           jumps straight to DONE instead of iterating.
// Ports   : i_clk            clock, rising edge
//           i_rst_n          asynchronous active-low reset
//           i_clear_a_load_b clear A / load dividend request (IDLE only)
//           i_run            start request (IDLE only), held to stay in DONE
//           i_dbz            divisor-is-zero (only with DIVIDER_DBZ_TRAP_EN)
//           o_ld_b           load dividend into B, clear X
//           o_ld_d           latch divisor, set X from divisor==0
//           o_step           perform one restoring iteration
//           o_clr_a          clear A
module divider_control
  import divider_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear_a_load_b,
  input  logic i_run,
`ifdef DIVIDER_DBZ_TRAP_EN
  input  logic i_dbz,
`endif
  output logic o_ld_b,
  output logic o_ld_d,
  output logic o_step,
  output logic o_clr_a
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    o_ld_b      = 1'b0;
    o_ld_d      = 1'b0;
    o_step      = 1'b0;
    o_clr_a     = 1'b0;
    case (r_state)
      IDLE: begin
        // Load has priority: a simultaneous Run is dropped, not deferred.
        if (i_clear_a_load_b) begin
          o_ld_b  = 1'b1;
          o_clr_a = 1'b1;
        end else if (i_run) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        o_ld_d      = 1'b1;
        w_count_nxt = '0;
`ifdef DIVIDER_DBZ_TRAP_EN
        // A is not cleared on the trap path: the datapath moves B into A.
        if (i_dbz) begin
          w_state_nxt = DONE;
        end else begin
          o_clr_a     = 1'b1;
          w_state_nxt = STEP;
        end
`else
        o_clr_a     = 1'b1;
        w_state_nxt = STEP;
`endif
      end
      STEP: begin
        o_step = 1'b1;
        // Counter parks at its last value rather than wrapping.
        if (r_count == CNT_W'(ITER - 1)) begin
          w_state_nxt = DONE;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      DONE: begin
        // Holding Run keeps us here so a long press yields one division.
        if (!i_run) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - 8-bit sequential restoring divider with hex displays
//
// Purpose : B holds the dividend and becomes the quotient, A becomes the
//           remainder, D latches the divisor at start. One quotient bit per
//           STEP cycle. Optional macro DIVIDER_DBZ_TRAP_EN shortcuts a zero
//           divisor to the final result in LOAD.
// Ports   : Clk           clock, rising edge
//           Reset         asynchronous active-low reset
//           ClearA_LoadB  clear A, load S into B (IDLE only)
//           Run           start a division with divisor S (IDLE only)
//           S [7:0]       switch value
//           Aval [7:0]    A register (remainder)
//           Bval [7:0]    B register (quotient)
//           X             divide-by-zero flag
//           AhexU/AhexL   segment images of A[7:4] / A[3:0]
//           BhexU/BhexL   segment images of B[7:4] / B[3:0]
module restoring_divider
  import divider_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic [6:0]       AhexU,
  output logic [6:0]       AhexL,
  output logic [6:0]       BhexU,
  output logic [6:0]       BhexL
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_x;

  logic             w_ld_b;
  logic             w_ld_d;
  logic             w_step;
  logic             w_clr_a;
  logic             w_s_zero;

  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_a_next;

  assign w_s_zero = (S == '0);

  divider_control u_ctrl (
    .i_clk            (Clk),
    .i_rst_n          (Reset),
    .i_clear_a_load_b (ClearA_LoadB),
    .i_run            (Run),
`ifdef DIVIDER_DBZ_TRAP_EN
    .i_dbz            (w_s_zero),
`endif
    .o_ld_b           (w_ld_b),
    .o_ld_d           (w_ld_d),
    .o_step           (w_step),
    .o_clr_a          (w_clr_a)
  );

  // Partial remainder shifted left with the next dividend bit; a 9-bit
  // compare is needed because the shifted value can exceed 8 bits.
  assign w_t      = {r_a, r_b[WIDTH-1]};
  assign w_diff   = w_t - {1'b0, r_d};
  assign w_ge     = (w_t >= {1'b0, r_d});
  assign w_a_next = w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_a <= '0;
    end else if (w_clr_a) begin
      r_a <= '0;
    end else if (w_step) begin
      r_a <= w_a_next;
`ifdef DIVIDER_DBZ_TRAP_EN
    end else if (w_ld_d && w_s_zero) begin
      r_a <= r_b;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_b <= '0;
    end else if (w_ld_b) begin
      r_b <= S;
    end else if (w_step) begin
      r_b <= {r_b[WIDTH-2:0], w_ge};
`ifdef DIVIDER_DBZ_TRAP_EN
    end else if (w_ld_d && w_s_zero) begin
      r_b <= '1;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_d <= '0;
    end else if (w_ld_d) begin
      r_d <= S;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_x <= 1'b0;
    end else if (w_ld_b) begin
      r_x <= 1'b0;
    end else if (w_ld_d) begin
      r_x <= w_s_zero;
    end
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign X    = r_x;

  HexDriver u_hex_au (.i_hex(r_a[7:4]), .o_seg(AhexU));
  HexDriver u_hex_al (.i_hex(r_a[3:0]), .o_seg(AhexL));
  HexDriver u_hex_bu (.i_hex(r_b[7:4]), .o_seg(BhexU));
  HexDriver u_hex_bl (.i_hex(r_b[3:0]), .o_seg(BhexL));

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - self-checking bench for restoring_divider
module tb_restoring_divider;
  import divider_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       ClearA_LoadB;
  logic       Run;
  logic [7:0] S;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic [6:0] AhexU;
  logic [6:0] AhexL;
  logic [6:0] BhexU;
  logic [6:0] BhexL;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       x;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_dividend;

  restoring_divider dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ClearA_LoadB (ClearA_LoadB),
    .Run          (Run),
    .S            (S),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .AhexU        (AhexU),
    .AhexL        (AhexL),
    .BhexU        (BhexU),
    .BhexL        (BhexL)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic int st();
    return int'(dut.u_ctrl.r_state);
  endfunction

  function automatic int lat_for(input logic [7:0] d);
`ifdef DIVIDER_DBZ_TRAP_EN
    if (d == 8'd0) return 2;
`endif
    return 10;
  endfunction

  task automatic load_b(input logic [7:0] v);
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    S            = v;
    @(posedge Clk);
    #1;
    check("load_b", Bval, v);
    check("load_a", Aval, 0);
    check("load_x", X, 0);
    m_dividend = v;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d);
    exp_t e;
    if (d == 8'd0) begin
      e.q = 8'hFF;
      e.r = m_dividend;
      e.x = 1'b1;
    end else begin
      e.q = m_dividend / d;
      e.r = m_dividend % d;
      e.x = 1'b0;
    end
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_q"}, Bval, e.q);
    check({tag, "_r"}, Aval, e.r);
    check({tag, "_x"}, X, e.x);
    check({tag, "_done"}, st(), int'(DONE));
  endtask

  task automatic do_div(input string tag, input logic [7:0] d);
    int lat;
    lat = lat_for(d);
    @(negedge Clk);
    Run = 1'b1;
    S   = d;
    push_exp(d);
    repeat (lat - 1) @(posedge Clk);
    #1;
    check({tag, "_early"}, (st() == int'(DONE)) ? 1 : 0, 0);
    @(posedge Clk);
    #1;
    pop_check(tag);
    @(negedge Clk);
    Run = 1'b0;
    @(posedge Clk);
    #1;
    check({tag, "_idle"}, st(), int'(IDLE));
  endtask

  initial begin
    Reset        = 1'b0;
    ClearA_LoadB = 1'b0;
    Run          = 1'b0;
    S            = 8'h00;
    m_dividend   = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_a", Aval, 0);
    check("rst_b", Bval, 0);
    check("rst_x", X, 0);
    check("rst_state", st(), int'(IDLE));
    check("rst_hex", BhexL, seg_of(4'h0));
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("post_rst_idle", st(), int'(IDLE));

    // 100 / 7 = 14 r 2
    load_b(8'd100);
    do_div("d100_7", 8'd7);
    check("hex_au", AhexU, seg_of(Aval[7:4]));
    check("hex_al", AhexL, seg_of(4'h2));
    check("hex_bu", BhexU, seg_of(4'h0));
    check("hex_bl", BhexL, seg_of(4'hE));

    load_b(8'd255);
    do_div("d255_1", 8'd1);
    load_b(8'd5);
    do_div("d5_9", 8'd9);
    load_b(8'hA5);
    do_div("dbz", 8'd0);
    check("dbz_hex_au", AhexU, seg_of(4'hA));

    // Run held 30 clocks; S and ClearA_LoadB disturbed after LOAD.
    load_b(8'd200);
    @(negedge Clk);
    Run = 1'b1;
    S   = 8'd13;
    push_exp(8'd13);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    S            = 8'd3;
    ClearA_LoadB = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    pop_check("held");
    repeat (20) @(posedge Clk);
    #1;
    check("held_state", st(), int'(DONE));
    check("held_q", Bval, 8'd15);
    check("held_r", Aval, 8'd5);
    @(negedge Clk);
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    @(posedge Clk);
    #1;
    check("held_idle", st(), int'(IDLE));
    repeat (3) @(posedge Clk);
    #1;
    check("held_no_rerun", st(), int'(IDLE));

    // Reset asserted during the 4th STEP cycle.
    load_b(8'd50);
    @(negedge Clk);
    Run = 1'b1;
    S   = 8'd3;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    check("pre_rst_step", st(), int'(STEP));
    Reset = 1'b0;
    Run   = 1'b0;
    #1;
    check("mid_rst_a", Aval, 0);
    check("mid_rst_b", Bval, 0);
    check("mid_rst_x", X, 0);
    check("mid_rst_state", st(), int'(IDLE));
    #2;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("mid_rst_stay_idle", st(), int'(IDLE));
    load_b(8'd50);
    do_div("after_rst", 8'd3);

    // Run and ClearA_LoadB together: load wins, no division.
    @(negedge Clk);
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    S            = 8'h33;
    @(posedge Clk);
    #1;
    check("both_b", Bval, 8'h33);
    check("both_a", Aval, 0);
    check("both_state", st(), int'(IDLE));
    @(negedge Clk);
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("both_no_div", st(), int'(IDLE));
    check("both_b_hold", Bval, 8'h33);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] dv;
      load_b(8'($urandom_range(0, 255)));
      dv = 8'($urandom_range(1, 255));
      do_div("rand", dv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have ports: Clk  in  1  system clock; all state on its rising edge.
REQ-002 The block SHALL have ports: Reset  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have ports: ClearA_LoadB  in  1  active-high, pre-synchronized; clears A and loads dividend into B.
REQ-004 The block SHALL have ports: Run  in  1  active-high, pre-synchronized; starts one division.
REQ-005 The block SHALL have ports: S  in  8  switch value; dividend on load, divisor on start.
REQ-006 The block SHALL have ports: Aval  out  8  A register, remainder after completion.
REQ-007 The block SHALL have ports: Bval  out  8  B register, quotient after completion.
REQ-008 The block SHALL have ports: X  out  1  divide-by-zero flag, registered.
REQ-009 The block SHALL have ports: AhexU, AhexL, BhexU, BhexL  out  7 each  seven-segment images of A[7:4], A[3:0], B[7:4], B[3:0].

Function
REQ-010 The FSM SHALL have states IDLE, LOAD, STEP, DONE.
REQ-011 In IDLE with ClearA_LoadB=1, the block SHALL set A<=0, B<=S, X<=0 at the next edge.
REQ-012 In IDLE with Run=1 and ClearA_LoadB=0, the next state SHALL be LOAD.
REQ-013 If Run and ClearA_LoadB are both 1 in IDLE, ClearA_LoadB SHALL win and Run SHALL be ignored that cycle.
REQ-014 In LOAD, the block SHALL set A<=0, D<=S (internal 8-bit divisor latch), X<=(S==0), count<=0, and go to STEP.
REQ-015 Each STEP cycle SHALL form T={A,B[7]} (9 bits) and compare it with {1'b0,D}.
REQ-016 If T>={0,D}, then A<=T-D (low 8 bits) and B<={B[6:0],1}; otherwise A<=T[7:0] and B<={B[6:0],0}.
REQ-017 STEP SHALL run exactly 8 cycles (count 0..7); after the eighth it SHALL go to DONE.
REQ-018 The 3-bit count SHALL NOT wrap beyond 7.
REQ-019 Results SHALL be valid in DONE, which is 10 clocks after Run is sampled in IDLE.
REQ-020 DONE SHALL hold A, B, X stable until Run=0, then return to IDLE; a held Run SHALL yield exactly one division.
REQ-021 ClearA_LoadB and S changes SHALL be ignored in LOAD, STEP, and DONE.
REQ-022 A divisor of 0 SHALL yield B=8'hFF, A=dividend, X=1.
REQ-023 Hex outputs SHALL be combinational decodes of the A and B registers.

Reset
REQ-024 Reset=0 SHALL asynchronously force state=IDLE, A=0, B=0, D=0, count=0, X=0, at any time including mid-STEP.
REQ-025 After Reset deasserts, no operation SHALL start until a Run is sampled in IDLE.

Configuration
REQ-026 With DIVIDER_DBZ_TRAP_EN defined, LOAD with S==0 SHALL set X=1, A<=B, B<=8'hFF and go directly to DONE, so results are valid 2 clocks after Run.
REQ-027 Without DIVIDER_DBZ_TRAP_EN, division by zero SHALL iterate normally through 8 STEP cycles, giving identical A, B, X values at 10 clocks.

Structure
REQ-028 Package divider_pkg SHALL hold the WIDTH=8 constant, the ITER=8 constant, and the state enum type.
REQ-029 The FSM SHALL live in sub-module divider_control, which outputs ld_b, ld_d, step, clr_a.
REQ-030 Datapath registers SHALL be in restoring_divider, with the existing HexDriver instantiated four times.

Verification
REQ-031 ClearA_LoadB with S=100, then Run with S=7 -> Bval=0x0E, Aval=0x02, X=0, DONE after 10 clocks.
REQ-032 Load 255, Run with S=1 -> Bval=0xFF, Aval=0x00; load 5, divide by 9 -> Bval=0x00, Aval=0x05.
REQ-033 Load 0xA5, Run with S=0 -> Bval=0xFF, Aval=0xA5, X=1; latency 10 clocks, or 2 clocks with DIVIDER_DBZ_TRAP_EN.
REQ-034 Run held high 30 clocks with S toggled after LOAD -> one division using the latched divisor; IDLE is re-entered only after Run falls.
REQ-035 Reset pulsed during the 4th STEP cycle -> A=B=0, X=0, IDLE immediately; the next Run starts a clean division.
REQ-036 Run and ClearA_LoadB asserted together in IDLE with S=0x33 -> B=0x33, A=0, and no division starts.
